mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Left-to-right binary modular exponentiation controller: result = X^E mod M.
- Sits directly upstream of the Montgomery multiplier. It drives that multiplier's start and operand inputs (a, b, m) and consumes its result and done outputs.
- Performs to-Montgomery conversion, square/multiply sequencing over the exponent bits, then from-Montgomery conversion.
- Makes no arithmetic of its own beyond operand muxing and exponent-bit selection.

Parameters:
- N_WIDTH, 1024, operand/modulus width.
- E_WIDTH, 1024, exponent register width.
- LEN_WIDTH, 11, width of exponent bit-length input; must hold values 0..E_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_x  in  N_WIDTH  base X, with X < M.
- in_e  in  E_WIDTH  exponent E.
- in_elen  in  LEN_WIDTH  number of significant exponent bits t; bits at index >= t are ignored.
- in_m  in  N_WIDTH  odd modulus M.
- in_r  in  N_WIDTH  R mod M, where R = 2^N_WIDTH.
- in_r2  in  N_WIDTH  R^2 mod M.
- mul_start  out  1  one-cycle pulse launching one Montgomery product.
- mul_a  out  N_WIDTH  multiplier operand a.
- mul_b  out  N_WIDTH  multiplier operand b.
- mul_m  out  N_WIDTH  multiplier modulus; equals the latched M.
- mul_result  in  N_WIDTH  multiplier output a*b*R^-1 mod M.
- mul_done  in  1  one-cycle pulse; mul_result is valid in the same cycle.
- result  out  N_WIDTH  X^E mod M; held until the next accepted start.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high from accepted start until the cycle done pulses (inclusive).

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - mul_start=0, done=0, busy=0.
  - result=0, mul_a=0, mul_b=0, mul_m=0.
  - All internal registers cleared.
- Reset mid-operation aborts immediately. After release the block is idle; any in-flight mul_done is ignored.
- Latch on start in IDLE: X, E, t, M, R, R2 are registered.
  - Inputs may change afterwards without effect.
  - A start while busy is ignored. No queueing.
- Registers: A (accumulator, N_WIDTH); Xm (X in Montgomery form); i (bit index, LEN_WIDTH).
- States and transitions:
  - IDLE -> CONV_IN on start.
  - CONV_IN: issue (X, R2); on mul_done, Xm <= mul_result, A <= R, i <= t. Go to CHECK.
  - CHECK:
    - if i==0, go to CONV_OUT.
    - else i <= i-1 and go to SQUARE.
  - SQUARE: issue (A, A); on mul_done, A <= mul_result.
    - If E[i]=1, go to MULT.
    - Else go to CHECK.
  - MULT: issue (A, Xm); on mul_done, A <= mul_result. Go to CHECK.
  - CONV_OUT: issue (A, 1); on mul_done, result <= mul_result. Go to FINISH.
  - FINISH: done=1 for one cycle, then IDLE.
- Issue protocol, for each multiply state:
  - On the first cycle in the state, mul_a/mul_b are set and mul_start is pulsed for exactly 1 cycle.
  - mul_a/mul_b are held stable until mul_done.
  - The block waits indefinitely for mul_done. mul_done in any non-waiting cycle, including IDLE, is ignored.
- Multiply count = 2 + t + popcount(E[t-1:0]).
- Per multiply, total cycles = 1 issue cycle + multiplier latency. CHECK costs 1 cycle each visit.
- done rises 1 cycle after the final mul_done; busy falls 1 cycle after done.
- t == 0: result = 1 mod M (2 multiplies). If M==1, result = 0.
- t > E_WIDTH is illegal; behaviour is to clamp t to E_WIDTH.
- E bit selection uses index i after decrement, so bits are scanned MSB (t-1) down to 0.

Test Plan (N_WIDTH=8, E_WIDTH=8, LEN_WIDTH=4; behavioural multiplier model with fixed 4-cycle latency; M=13, R=9, R2=3):
- X=5, E=3, t=2, start -> exactly 6 mul_start pulses; result=8; done for 1 cycle; busy low after.
- X=2, E=4, t=3 -> 6 multiplies, with ops in order: (X,R2), square, mult, square, square, conv-out; result=3.
- X=7, E=0xFF, t=0 -> 2 multiplies; result=1; E bits ignored.
- start re-pulsed during the 3rd multiply; in_x changed mid-run -> ignored; result unchanged versus the clean run; exactly 1 done.
- resetn low during SQUARE -> all outputs 0 asynchronously. Then a late mul_done and a new start with X=5, E=3, t=2 -> spurious done ignored; result=8.
- Multiplier latency randomized 1..20 cycles, 50 random (X, E, t) runs -> result matches reference X^E mod 13; mul_a/mul_b stable throughout each wait.

Source files
------------

// File: rtl/mont_exp_ctrl_if.sv
// Montgomery multiplier request/response bus between the exponentiation controller and the multiplier.
interface mont_exp_ctrl_if #(
  parameter int unsigned N_WIDTH = 1024
) ();
  logic               mul_start;
  logic [N_WIDTH-1:0] mul_a;
  logic [N_WIDTH-1:0] mul_b;
  logic [N_WIDTH-1:0] mul_m;
  logic [N_WIDTH-1:0] mul_result;
  logic               mul_done;

  modport master (
    output mul_start, mul_a, mul_b, mul_m,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b, mul_m,
    output mul_result, mul_done
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation controller sequencing an external Montgomery multiplier.
// Computes X^E mod M with to/from-Montgomery conversion; all outputs registered.
module mont_exp_ctrl #(
  parameter int unsigned N_WIDTH   = 1024,
  parameter int unsigned E_WIDTH   = 1024,
  parameter int unsigned LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [N_WIDTH-1:0]   in_x,
  input  logic [E_WIDTH-1:0]   in_e,
  input  logic [LEN_WIDTH-1:0] in_elen,
  input  logic [N_WIDTH-1:0]   in_m,
  input  logic [N_WIDTH-1:0]   in_r,
  input  logic [N_WIDTH-1:0]   in_r2,
  mont_exp_ctrl_if.master      mul,
  output logic [N_WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONV_IN  = 3'd1,
    S_CHECK    = 3'd2,
    S_SQUARE   = 3'd3,
    S_MULT     = 3'd4,
    S_CONV_OUT = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  localparam logic [LEN_WIDTH-1:0] T_MAX = LEN_WIDTH'(E_WIDTH);

  state_t               r_state,     w_state_nx;
  logic [E_WIDTH-1:0]   r_e,         w_e_nx;
  logic [LEN_WIDTH-1:0] r_t,         w_t_nx;
  logic [LEN_WIDTH-1:0] r_i,         w_i_nx;
  logic [N_WIDTH-1:0]   r_r,         w_r_nx;
  logic [N_WIDTH-1:0]   r_acc,       w_acc_nx;
  logic [N_WIDTH-1:0]   r_xm,        w_xm_nx;
  logic [N_WIDTH-1:0]   r_result,    w_result_nx;
  logic [N_WIDTH-1:0]   r_mul_a,     w_mul_a_nx;
  logic [N_WIDTH-1:0]   r_mul_b,     w_mul_b_nx;
  logic [N_WIDTH-1:0]   r_mul_m,     w_mul_m_nx;
  logic                 r_mul_start, w_mul_start_nx;
  logic                 r_done,      w_done_nx;
  logic                 r_busy,      w_busy_nx;

  logic [LEN_WIDTH-1:0] w_t_clamp;
  logic                 w_ebit;
  logic                 w_ack;

  assign w_t_clamp = (in_elen > T_MAX) ? T_MAX : in_elen;
  assign w_ebit    = |(r_e & (E_WIDTH'(1) << r_i));
  // The issue cycle is not a waiting cycle, so a done arriving alongside our own start is not ours.
  assign w_ack     = mul.mul_done & ~r_mul_start;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_e         <= '0;
      r_t         <= '0;
      r_i         <= '0;
      r_r         <= '0;
      r_acc       <= '0;
      r_xm        <= '0;
      r_result    <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_m     <= '0;
      r_mul_start <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_e         <= w_e_nx;
      r_t         <= w_t_nx;
      r_i         <= w_i_nx;
      r_r         <= w_r_nx;
      r_acc       <= w_acc_nx;
      r_xm        <= w_xm_nx;
      r_result    <= w_result_nx;
      r_mul_a     <= w_mul_a_nx;
      r_mul_b     <= w_mul_b_nx;
      r_mul_m     <= w_mul_m_nx;
      r_mul_start <= w_mul_start_nx;
      r_done      <= w_done_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Next-state and next-output logic; operands are loaded on entry so they appear with mul_start.
  always_comb begin
    w_state_nx     = r_state;
    w_e_nx         = r_e;
    w_t_nx         = r_t;
    w_i_nx         = r_i;
    w_r_nx         = r_r;
    w_acc_nx       = r_acc;
    w_xm_nx        = r_xm;
    w_result_nx    = r_result;
    w_mul_a_nx     = r_mul_a;
    w_mul_b_nx     = r_mul_b;
    w_mul_m_nx     = r_mul_m;
    w_mul_start_nx = 1'b0;
    w_done_nx      = 1'b0;
    w_busy_nx      = r_busy;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_e_nx         = in_e;
          w_t_nx         = w_t_clamp;
          w_r_nx         = in_r;
          w_mul_m_nx     = in_m;
          w_mul_a_nx     = in_x;
          w_mul_b_nx     = in_r2;
          w_mul_start_nx = 1'b1;
          w_busy_nx      = 1'b1;
          w_state_nx     = S_CONV_IN;
        end
      end
      S_CONV_IN: begin
        if (w_ack) begin
          w_xm_nx    = mul.mul_result;
          w_acc_nx   = r_r;
          w_i_nx     = r_t;
          w_state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        w_mul_start_nx = 1'b1;
        w_mul_a_nx     = r_acc;
        if (r_i == '0) begin
          w_mul_b_nx = N_WIDTH'(1);
          w_state_nx = S_CONV_OUT;
        end else begin
          w_i_nx     = r_i - LEN_WIDTH'(1);
          w_mul_b_nx = r_acc;
          w_state_nx = S_SQUARE;
        end
      end
      S_SQUARE: begin
        if (w_ack) begin
          w_acc_nx = mul.mul_result;
          if (w_ebit) begin
            w_mul_start_nx = 1'b1;
            w_mul_a_nx     = mul.mul_result;
            w_mul_b_nx     = r_xm;
            w_state_nx     = S_MULT;
          end else begin
            w_state_nx = S_CHECK;
          end
        end
      end
      S_MULT: begin
        if (w_ack) begin
          w_acc_nx   = mul.mul_result;
          w_state_nx = S_CHECK;
        end
      end
      S_CONV_OUT: begin
        if (w_ack) begin
          w_result_nx = mul.mul_result;
          w_done_nx   = 1'b1;
          w_state_nx  = S_FINISH;
        end
      end
      S_FINISH: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign mul.mul_start = r_mul_start;
  assign mul.mul_a     = r_mul_a;
  assign mul.mul_b     = r_mul_b;
  assign mul.mul_m     = r_mul_m;
  assign result        = r_result;
  assign done          = r_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed and randomized bench for mont_exp_ctrl with a behavioural Montgomery multiplier (M=13, R=2^8).
module tb_mont_exp_ctrl;

  localparam int unsigned NW = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned LW = 4;
  localparam int MOD  = 13;
  localparam int RINV = 3;   // 256^-1 mod 13

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_elen = '0;
  logic [NW-1:0] in_m = 8'd13;
  logic [NW-1:0] in_r = 8'd9;
  logic [NW-1:0] in_r2 = 8'd3;
  logic [NW-1:0] result;
  logic          done;
  logic          busy;

  mont_exp_ctrl_if #(.N_WIDTH(NW)) mul_if ();

  mont_exp_ctrl #(.N_WIDTH(NW), .E_WIDTH(EW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_elen(in_elen),
    .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .mul(mul_if.master),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural multiplier state
  logic          m_done = 1'b0;
  logic          inj_done = 1'b0;
  logic [NW-1:0] m_res = '0;
  logic          m_pend = 1'b0;
  int            m_cnt = 0;
  logic [NW-1:0] la = '0, lb = '0;
  int            fix_lat = 4;
  bit            rand_lat = 1'b0;
  int            n_starts = 0;
  int            n_done = 0;
  int            mon_err = 0;
  logic [NW-1:0] op_a [64];
  logic [NW-1:0] op_b [64];
  int            cur_lat;

  assign mul_if.mul_done   = m_done | inj_done;
  assign mul_if.mul_result = m_res;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_done <= 1'b0;
      m_pend <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (mul_if.mul_start) begin
        cur_lat = rand_lat ? int'($urandom_range(1, 20)) : fix_lat;
        la <= mul_if.mul_a;
        lb <= mul_if.mul_b;
        m_res <= NW'((int'(mul_if.mul_a) * int'(mul_if.mul_b) * RINV) % MOD);
        op_a[n_starts % 64] <= mul_if.mul_a;
        op_b[n_starts % 64] <= mul_if.mul_b;
        n_starts <= n_starts + 1;
        if (cur_lat <= 1) begin
          m_done <= 1'b1;
        end else begin
          m_pend <= 1'b1;
          m_cnt  <= cur_lat - 1;
        end
      end else if (m_pend) begin
        if (mul_if.mul_a !== la || mul_if.mul_b !== lb) mon_err <= mon_err + 1;
        if (m_cnt <= 1) begin
          m_done <= 1'b1;
          m_pend <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) if (done) n_done <= n_done + 1;

  function automatic int ref_exp(input int x, input int e, input int t);
    int r, tt;
    tt = (t > 8) ? 8 : t;
    r = 1 % MOD;
    for (int k = tt - 1; k >= 0; k--) begin
      r = (r * r) % MOD;
      if (((e >> k) & 1) == 1) r = (r * x) % MOD;
    end
    return r;
  endfunction

  task automatic run_exp(input logic [NW-1:0] x, input logic [EW-1:0] e, input logic [LW-1:0] t,
                         input bit disturb, output logic [NW-1:0] res, output int nmul,
                         output int ndone, output logic busy_at_done, output bit tmo);
    int  s0, d0;
    bit  dist_done;
    s0 = n_starts; d0 = n_done; tmo = 1'b1; dist_done = 1'b0;
    res = '0; busy_at_done = 1'b0;
    @(negedge clk);
    in_x = x; in_e = e; in_elen = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        tmo = 1'b0;
        res = result;
        busy_at_done = busy;
        break;
      end
      if (disturb && !dist_done && (n_starts - s0) >= 3) begin
        start = 1'b1; in_x = 8'd9; in_e = 8'hAA; in_elen = 4'd7; dist_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    nmul  = n_starts - s0;
    ndone = n_done - d0;
    tests_run++;
    if (tmo) begin
      tests_failed++;
      $display("FAIL timeout: no done for x=%0d e=%0d t=%0d", x, e, t);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (result !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: result=%0d done=%0b busy=%0b required 0/0/0", result, done, busy);
    end
    tests_run++;
    if (mul_if.mul_start !== 1'b0 || mul_if.mul_a !== 8'd0 || mul_if.mul_b !== 8'd0 || mul_if.mul_m !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mul: start=%0b a=%0d b=%0d m=%0d required all 0",
               mul_if.mul_start, mul_if.mul_a, mul_if.mul_b, mul_if.mul_m);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_run(input string name, input logic [NW-1:0] res, input logic [NW-1:0] exp_res,
                           input int nmul, input int exp_mul, input int ndone, input logic bad);
    tests_run++;
    if (res !== exp_res) begin
      tests_failed++;
      $display("FAIL %s result: got %0d required %0d", name, res, exp_res);
    end
    tests_run++;
    if (nmul != exp_mul) begin
      tests_failed++;
      $display("FAIL %s mul_count: got %0d required %0d", name, nmul, exp_mul);
    end
    tests_run++;
    if (ndone != 1 || bad) begin
      tests_failed++;
      $display("FAIL %s done/busy: done_pulses=%0d required 1, busy/done handshake error=%0b", name, ndone, bad);
    end
  endtask

  task automatic test_basic();
    logic [NW-1:0] res; int nm, nd; logic bad; bit tmo;
    fix_lat = 4;
    run_exp(8'd5, 8'd3, 4'd2, 1'b0, res, nm, nd, bad, tmo);
    bad = !bad || busy !== 1'b0 || done !== 1'b0;
    check_run("basic", res, 8'd8, nm, 6, nd, bad);
  endtask

  task automatic test_op_order();
    logic [NW-1:0] res; int nm, nd, s0; logic bad; bit tmo;
    logic [NW-1:0] ea [6];
    logic [NW-1:0] eb [6];
    ea = '{8'd2, 8'd9, 8'd9, 8'd5, 8'd10, 8'd1};
    eb = '{8'd3, 8'd9, 8'd5, 8'd5, 8'd10, 8'd1};
    s0 = n_starts;
    run_exp(8'd2, 8'd4, 4'd3, 1'b0, res, nm, nd, bad, tmo);
    bad = !bad || busy !== 1'b0;
    check_run("op_order", res, 8'd3, nm, 6, nd, bad);
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (op_a[(s0 + k) % 64] !== ea[k] || op_b[(s0 + k) % 64] !== eb[k]) begin
        tests_failed++;
        $display("FAIL op_order op%0d: got (%0d,%0d) required (%0d,%0d)", k,
                 op_a[(s0 + k) % 64], op_b[(s0 + k) % 64], ea[k], eb[k]);
      end
    end
    tests_run++;
    if (mul_if.mul_m !== 8'd13) begin
      tests_failed++;
      $display("FAIL mul_m: got %0d required 13", mul_if.mul_m);
    end
  endtask

  task automatic test_t_zero();
    logic [NW-1:0] res; int nm, nd; logic bad; bit tmo;
    run_exp(8'd7, 8'hFF, 4'd0, 1'b0, res, nm, nd, bad, tmo);
    check_run("t_zero", res, 8'd1, nm, 2, nd, !bad);
  endtask

  task automatic test_clamp();
    logic [NW-1:0] res; int nm, nd; logic bad; bit tmo;
    run_exp(8'd3, 8'h05, 4'd15, 1'b0, res, nm, nd, bad, tmo);
    check_run("clamp_t15", res, 8'd9, nm, 2 + 8 + 2, nd, !bad);
    run_exp(8'd2, 8'hFF, 4'd8, 1'b0, res, nm, nd, bad, tmo);
    check_run("full_t8", res, 8'd8, nm, 2 + 8 + 8, nd, !bad);
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] res; int nm, nd; logic bad; bit tmo;
    run_exp(8'd5, 8'd3, 4'd2, 1'b1, res, nm, nd, bad, tmo);
    check_run("restart_ignored", res, 8'd8, nm, 6, nd, !bad);
  endtask

  task automatic test_reset_mid();
    logic [NW-1:0] res; int nm, nd, s0, d0; logic bad; bit tmo;
    s0 = n_starts;
    @(negedge clk);
    in_x = 8'd5; in_e = 8'd3; in_elen = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && (n_starts - s0) < 2; k++) @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid precondition: busy=%0b required 1", busy);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mul_if.mul_start !== 1'b0 || mul_if.mul_a !== 8'd0 ||
        mul_if.mul_b !== 8'd0 || mul_if.mul_m !== 8'd0 || result !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid async: busy=%0b done=%0b start=%0b a=%0d b=%0d m=%0d result=%0d required all 0",
               busy, done, mul_if.mul_start, mul_if.mul_a, mul_if.mul_b, mul_if.mul_m, result);
    end
    @(negedge clk);
    resetn = 1'b1;
    d0 = n_done;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (n_done != d0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_done: done_pulses=%0d busy=%0b required 0/0", n_done - d0, busy);
    end
    run_exp(8'd5, 8'd3, 4'd2, 1'b0, res, nm, nd, bad, tmo);
    check_run("after_reset", res, 8'd8, nm, 6, nd, !bad);
  endtask

  task automatic test_random();
    logic [NW-1:0] res; int nm, nd, e0, x, e, t, exp_r; logic bad; bit tmo;
    e0 = mon_err;
    rand_lat = 1'b1;
    for (int n = 0; n < 50; n++) begin
      x = int'($urandom_range(0, 12));
      e = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 10));
      exp_r = ref_exp(x, e, t);
      run_exp(NW'(x), EW'(e), LW'(t), 1'b0, res, nm, nd, bad, tmo);
      tests_run++;
      if (res !== NW'(exp_r) || nd != 1) begin
        tests_failed++;
        $display("FAIL random run%0d x=%0d e=%0d t=%0d: got %0d (dones %0d) required %0d", n, x, e, t, res, nd, exp_r);
      end
    end
    rand_lat = 1'b0;
    tests_run++;
    if (mon_err != e0) begin
      tests_failed++;
      $display("FAIL operand_stability: %0d unstable wait cycles, required 0", mon_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_op_order();
    test_t_zero();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
